cpx_energy_detect: RTL and testbench

Downstream consumer of the Hilbert real-to-complex stage. Takes the 13-bit signed analytic-signal pair (re, im) for each accepted sample and computes instantaneous power re²+im². It averages that power over a sliding window of 2^WIN_LOG2 samples and runs a hysteresis detection FSM against programmable thresholds. On each detection it reports a detect level, a start pulse and the sample index (time of arrival) of the ping, for the USBL ranging/bearing logic.

---
 rtl/cpx_energy_detect_if.sv | 23 ++
 rtl/cpx_energy_detect.sv | 192 +++++++++++++++++++
 tb/tb_cpx_energy_detect.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/cpx_energy_detect_if.sv
// rtl/cpx_energy_detect_if.sv - analytic-sample input and detection-result bundle for cpx_energy_detect
interface cpx_energy_detect_if #(
    parameter int CNT_W = 16
);
    logic                    data_rdy;
    logic signed [12:0]      re;
    logic signed [12:0]      im;
    logic        [25:0]      energy;
    logic                    energy_vld;
    logic                    det;
    logic                    det_start;
    logic        [CNT_W-1:0] toa;

    modport master (
        output data_rdy, re, im,
        input  energy, energy_vld, det, det_start, toa
    );

    modport slave (
        input  data_rdy, re, im,
        output energy, energy_vld, det, det_start, toa
    );
endinterface

// File: rtl/cpx_energy_detect.sv
// rtl/cpx_energy_detect.sv - sliding-window mean power of a complex stream with hysteresis ping detection
module cpx_energy_detect #(
    parameter int WIN_LOG2 = 4,
    parameter int HOLD_SMP = 8,
    parameter int CNT_W    = 16
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_clr,
    input  logic [25:0] i_thr_on,
    input  logic [25:0] i_thr_off,
    cpx_energy_detect_if.slave s_if
);
    localparam int WIN    = 1 << WIN_LOG2;
    localparam int SUM_W  = 26 + WIN_LOG2;
    localparam int HOLD_W = $clog2(HOLD_SMP + 1) + 1;
    localparam logic [WIN_LOG2:0] FILL_FULL = (WIN_LOG2 + 1)'(WIN);

    typedef enum logic [1:0] {
        S_FILL,
        S_ARMED,
        S_DETECT,
        S_HOLD
    } state_t;

    // Stage 1: exact power; each square is at most 2^24 so both fit a signed 26-bit product
    logic signed [25:0] w_re_ext;
    logic signed [25:0] w_im_ext;
    logic signed [25:0] w_re_sq;
    logic signed [25:0] w_im_sq;
    logic        [25:0] w_sq;

    assign w_re_ext = {{13{s_if.re[12]}}, s_if.re};
    assign w_im_ext = {{13{s_if.im[12]}}, s_if.im};
    assign w_re_sq  = w_re_ext * w_re_ext;
    assign w_im_sq  = w_im_ext * w_im_ext;
    assign w_sq     = $unsigned(w_re_sq) + $unsigned(w_im_sq);

    logic        r_s1_vld;
    logic [25:0] r_sq;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_s1_vld <= 1'b0;
            r_sq     <= '0;
        end else if (i_clr) begin
            r_s1_vld <= 1'b0;
            r_sq     <= '0;
        end else begin
            r_s1_vld <= s_if.data_rdy;
            if (s_if.data_rdy) begin
                r_sq <= w_sq;
            end
        end
    end

    // Stage 2: running window sum, oldest entry replaced in place
    logic [25:0]         r_buf [WIN];
    logic [WIN_LOG2-1:0] r_wr_ptr;
    logic [SUM_W-1:0]    r_sum;
    logic [CNT_W-1:0]    r_sample_cnt;
    logic [CNT_W-1:0]    r_idx;
    logic [WIN_LOG2:0]   r_fill;
    logic                r_s2_vld;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            for (int k = 0; k < WIN; k++) begin
                r_buf[k] <= '0;
            end
            r_wr_ptr     <= '0;
            r_sum        <= '0;
            r_sample_cnt <= '0;
            r_idx        <= '0;
            r_fill       <= '0;
            r_s2_vld     <= 1'b0;
        end else if (i_clr) begin
            for (int k = 0; k < WIN; k++) begin
                r_buf[k] <= '0;
            end
            r_wr_ptr     <= '0;
            r_sum        <= '0;
            r_sample_cnt <= '0;
            r_idx        <= '0;
            r_fill       <= '0;
            r_s2_vld     <= 1'b0;
        end else begin
            r_s2_vld <= r_s1_vld;
            if (r_s1_vld) begin
                r_sum           <= r_sum + SUM_W'(r_sq) - SUM_W'(r_buf[r_wr_ptr]);
                r_buf[r_wr_ptr] <= r_sq;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
                r_idx           <= r_sample_cnt;
                r_sample_cnt    <= r_sample_cnt + 1'b1;
                if (r_fill != FILL_FULL) begin
                    r_fill <= r_fill + 1'b1;
                end
            end
        end
    end

    // Stage 3: mean power and detection FSM, evaluated only on valid samples
    logic [25:0] w_energy_new;
    logic        w_win_done;
    logic        w_trigger;

    assign w_energy_new = r_sum[SUM_W-1:WIN_LOG2];
    assign w_win_done   = (r_fill == FILL_FULL);
    assign w_trigger    = (w_energy_new >= i_thr_on);

    state_t           r_state;
    logic [25:0]      r_energy;
    logic             r_energy_vld;
    logic             r_det;
    logic             r_det_start;
    logic [CNT_W-1:0] r_toa;
    logic [HOLD_W-1:0] r_hold_cnt;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state      <= S_FILL;
            r_energy     <= '0;
            r_energy_vld <= 1'b0;
            r_det        <= 1'b0;
            r_det_start  <= 1'b0;
            r_toa        <= '0;
            r_hold_cnt   <= '0;
        end else if (i_clr) begin
            r_state      <= S_FILL;
            r_energy     <= '0;
            r_energy_vld <= 1'b0;
            r_det        <= 1'b0;
            r_det_start  <= 1'b0;
            r_toa        <= '0;
            r_hold_cnt   <= '0;
        end else begin
            r_energy_vld <= r_s2_vld;
            r_det_start  <= 1'b0;
            if (r_s2_vld) begin
                r_energy <= w_energy_new;
                case (r_state)
                    S_FILL: begin
                        // the window-completing sample is also judged against thr_on
                        if (w_win_done) begin
                            if (w_trigger) begin
                                r_state     <= S_DETECT;
                                r_det       <= 1'b1;
                                r_det_start <= 1'b1;
                                r_toa       <= r_idx;
                            end else begin
                                r_state <= S_ARMED;
                            end
                        end
                    end
                    S_ARMED: begin
                        if (w_trigger) begin
                            r_state     <= S_DETECT;
                            r_det       <= 1'b1;
                            r_det_start <= 1'b1;
                            r_toa       <= r_idx;
                        end
                    end
                    S_DETECT: begin
                        if (w_energy_new < i_thr_off) begin
                            r_state    <= S_HOLD;
                            r_det      <= 1'b0;
                            r_hold_cnt <= HOLD_W'(HOLD_SMP);
                        end
                    end
                    S_HOLD: begin
                        if (r_hold_cnt <= HOLD_W'(1)) begin
                            r_state    <= S_ARMED;
                            r_hold_cnt <= '0;
                        end else begin
                            r_hold_cnt <= r_hold_cnt - 1'b1;
                        end
                    end
                    default: begin
                        r_state <= S_FILL;
                        r_det   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign s_if.energy     = r_energy;
    assign s_if.energy_vld = r_energy_vld;
    assign s_if.det        = r_det;
    assign s_if.det_start  = r_det_start;
    assign s_if.toa        = r_toa;
endmodule

// File: tb/tb_cpx_energy_detect.sv
// tb/tb_cpx_energy_detect.sv - directed bench for cpx_energy_detect
module tb_cpx_energy_detect;
    logic        clk;
    logic        reset;
    logic        clr;
    logic [25:0] thr_on;
    logic [25:0] thr_off;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_errors = 0;

    int q_e[$];
    int q_det[$];
    int q_ds[$];
    int q_toa[$];
    int q_cyc[$];
    int q_acc[$];

    cpx_energy_detect_if u_if ();

    cpx_energy_detect u_dut (
        .i_clk     (clk),
        .i_reset   (reset),
        .i_clr     (clr),
        .i_thr_on  (thr_on),
        .i_thr_off (thr_off),
        .s_if      (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (u_if.energy_vld === 1'b1) begin
            q_e.push_back(int'(u_if.energy));
            q_det.push_back(int'(u_if.det));
            q_ds.push_back(int'(u_if.det_start));
            q_toa.push_back(int'(u_if.toa));
            q_cyc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_q();
        q_e.delete();
        q_det.delete();
        q_ds.delete();
        q_toa.delete();
        q_cyc.delete();
        q_acc.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset         = 1'b0;
        clr           = 1'b0;
        u_if.data_rdy = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        clear_q();
    endtask

    task automatic send(input int r, input int i, input int gap);
        u_if.data_rdy = 1'b1;
        u_if.re       = 13'(r);
        u_if.im       = 13'(i);
        q_acc.push_back(cyc + 1);
        @(negedge clk);
        u_if.data_rdy = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic check_latency(input string tag);
        int bad;
        bad = 0;
        if (q_cyc.size() != q_acc.size()) bad++;
        foreach (q_cyc[k]) begin
            if (q_cyc[k] != q_acc[k] + 2) bad++;
        end
        check(tag, bad, 0);
    endtask

    task automatic run_a(input string p, input int gap);
        int n;
        do_reset();
        thr_on  = 26'd8000;
        thr_off = 26'd4000;
        for (int k = 0; k < 16; k++) send(100, 0, gap);
        for (int k = 0; k < 10; k++) send(0, 0, gap);
        for (int k = 0; k < 13; k++) send(100, 0, gap);
        repeat (4) @(negedge clk);
        check({p, "_nvld"}, q_e.size(), 39);
        check_latency({p, "_latency"});
        check({p, "_e7"}, q_e[7], 5000);
        check({p, "_e12"}, q_e[12], 8125);
        check({p, "_det12"}, q_det[12], 0);
        check({p, "_e14"}, q_e[14], 9375);
        check({p, "_e15"}, q_e[15], 10000);
        check({p, "_ds15"}, q_ds[15], 1);
        check({p, "_det15"}, q_det[15], 1);
        check({p, "_toa15"}, q_toa[15], 15);
        check({p, "_e24"}, q_e[24], 4375);
        check({p, "_det24"}, q_det[24], 1);
        check({p, "_e25"}, q_e[25], 3750);
        check({p, "_det25"}, q_det[25], 0);
        n = 0;
        for (int k = 26; k <= 37; k++) n += q_ds[k];
        check({p, "_hold_no_ds"}, n, 0);
        check({p, "_e31"}, q_e[31], 3750);
        check({p, "_e33"}, q_e[33], 5000);
        check({p, "_e37"}, q_e[37], 7500);
        check({p, "_e38"}, q_e[38], 8125);
        check({p, "_ds38"}, q_ds[38], 1);
        check({p, "_det38"}, q_det[38], 1);
        check({p, "_toa38"}, q_toa[38], 38);
        n = 0;
        foreach (q_ds[k]) n += q_ds[k];
        check({p, "_ds_total"}, n, 2);
    endtask

    initial begin
        int n;
        reset         = 1'b0;
        clr           = 1'b0;
        thr_on        = '0;
        thr_off       = '0;
        u_if.data_rdy = 1'b0;
        u_if.re       = '0;
        u_if.im       = '0;
        @(negedge clk);
        check("rst_energy", u_if.energy, 0);
        check("rst_vld", u_if.energy_vld, 0);
        check("rst_det", u_if.det, 0);
        check("rst_ds", u_if.det_start, 0);
        check("rst_toa", u_if.toa, 0);

        // reset asserted mid-stream while detecting with samples in flight
        do_reset();
        thr_on  = 26'd8000;
        thr_off = 26'd4000;
        for (int k = 0; k < 20; k++) send(100, 0, 0);
        check("mr_det_pre", u_if.det, 1);
        check("mr_vld_pre", u_if.energy_vld, 1);
        #2 reset = 1'b0;
        #1;
        check("mr_energy", u_if.energy, 0);
        check("mr_det", u_if.det, 0);
        check("mr_vld", u_if.energy_vld, 0);
        check("mr_toa", u_if.toa, 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        clear_q();
        repeat (4) @(negedge clk);
        check("mr_flush", q_e.size(), 0);

        run_a("cont", 0);
        run_a("gap", 4);

        // full scale
        do_reset();
        thr_on  = 26'h3FF_FFFF;
        thr_off = 26'd0;
        for (int k = 0; k < 17; k++) send(-4096, -4096, 0);
        repeat (4) @(negedge clk);
        check("fs_nvld", q_e.size(), 17);
        check("fs_e0", q_e[0], 2097152);
        check("fs_e7", q_e[7], 16777216);
        check("fs_e15", q_e[15], 33554432);
        check("fs_e16", q_e[16], 33554432);
        check("fs_det16", q_det[16], 0);

        // synchronous clear during DETECT, coincident with a sample
        do_reset();
        thr_on  = 26'd8000;
        thr_off = 26'd4000;
        for (int k = 0; k < 18; k++) send(100, 0, 0);
        check("clr_det_pre", u_if.det, 1);
        clr           = 1'b1;
        u_if.data_rdy = 1'b1;
        u_if.re       = 13'd100;
        u_if.im       = 13'd0;
        @(negedge clk);
        clr           = 1'b0;
        u_if.data_rdy = 1'b0;
        clear_q();
        check("clr_det", u_if.det, 0);
        check("clr_energy", u_if.energy, 0);
        check("clr_toa", u_if.toa, 0);
        repeat (4) @(negedge clk);
        check("clr_flush", q_e.size(), 0);
        for (int k = 0; k < 16; k++) send(100, 0, 0);
        repeat (4) @(negedge clk);
        check("clr_nvld", q_e.size(), 16);
        check("clr_e0", q_e[0], 625);
        check("clr_e15", q_e[15], 10000);
        check("clr_ds15", q_ds[15], 1);
        check("clr_toa15", q_toa[15], 15);
        n = 0;
        foreach (q_ds[k]) n += q_ds[k];
        check("clr_ds_total", n, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
